regfile_dumper: RTL and testbench
=================================

# regfile_dumper

Hardware read-out engine for the 32-entry register file: on `start` it takes over the regfile `rs1` read port, walks registers 0..NREGS-1 in order, and streams each `(index, value)` pair to a consumer over a valid/ready handshake. It is the reader counterpart of the instruction-driven write path (decoder → ALU → regfile `wdata`). It replaces bench-side register scanning, so a checker or logger can consume end-of-program register state at its own pace. It also keeps a running 32-bit sum of all values sent, as a quick signature.

## Interface
- `NREGS`, 32: number of registers dumped (indices 0..NREGS-1).
- `AW`, 5: register index width.
- `DW`, 32: register data width.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a dump; sampled only in IDLE.
- `own` output 1: 1 while the dumper drives the regfile read port. It is the select for the `rs1` mux (1 = dumper address, 0 = decoder address).
- `rs1` output AW: regfile read address.
- `rv1` input DW: regfile combinational read data for `rs1`.
- `out_valid` output 1: `out_idx`/`out_data` hold a valid entry.
- `out_ready` input 1: consumer accepts the entry.
- `out_idx` output AW: register index of the current entry.
- `out_data` output DW: register value of the current entry.
- `busy` output 1: 1 in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last entry is accepted.
- `sum` output DW: modulo-2^DW sum of all accepted `out_data`; stable from `done` until the next accepted `start`.

## Operation
- State machine has four states: IDLE, READ, HOLD, FIN.
- IDLE:
  - `own`=0, `busy`=0, `out_valid`=0.
  - On `start`=1: set idx←0, sum←0, go to READ.
- READ:
  - `own`=1, `rs1`=idx.
  - At the clock edge: `out_data`←`rv1`, `out_idx`←idx, go to HOLD.
- HOLD:
  - `own`=1, `out_valid`=1.
  - `rs1` stays at idx. It is don't-care for correctness, because the data is already latched.
  - While `out_ready`=0, `out_idx`/`out_data` remain stable.
  - On `out_valid`&&`out_ready`: sum←sum+`out_data` (carry discarded).
    - If idx==NREGS-1: go to FIN.
    - Otherwise: idx←idx+1, go to READ.
- FIN:
  - `done`=1 for exactly this one cycle, `own`=0, `out_valid`=0.
  - Go to IDLE.
- `start` is ignored in READ, HOLD and FIN; there is no queuing.
- A `start` held high through FIN starts a new dump on the first IDLE cycle.
- idx never wraps: NREGS-1 is terminal.
- Register 0 is dumped like any other entry, with whatever the regfile returns (0 for a hardwired x0).
- The dumper never writes the regfile. The system must hold the regfile `we` low while `own`=1; that is a bench/system rule and is not checked by this block.
- Reset: every output goes low/zero immediately (`own`=0, `rs1`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `busy`=0, `done`=0, `sum`=0) and the state goes to IDLE. This applies mid-dump too, with no partial `done`.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycle 1: READ, with `own`=1 and `rs1`=0.
- Cycle 2: HOLD, with `out_valid`=1 and `out_idx`=0.
- With `out_ready` held at 1, each register takes 2 cycles.
  - The last transfer happens at the end of cycle 2·NREGS.
  - `done` is high in cycle 2·NREGS+1.
  - IDLE is reached in cycle 2·NREGS+2.
  - For NREGS=32 that means `done` is high in cycle 65.
- Every `out_ready`=0 cycle in HOLD adds exactly one cycle of latency.
- `own` is registered and rises one cycle after `start`. The decoder path must not rely on `rs1` during that cycle or while `busy`.
- `sum` updates on the accept edge, so `sum` is final in the FIN cycle.

## Test plan
- Directed dump:
  - Stimulus: write reg k = 3k for k=1..31 (x0=0), assert `start` for 1 cycle, hold `out_ready`=1.
  - Required: 32 beats with `out_idx`=0..31 and `out_data`=3·idx; `done` in cycle 65; `sum`=1488.
- Backpressure:
  - Stimulus: same regfile contents, with `out_ready` toggling 1,0,0,1,…
  - Required: no beat lost or duplicated; `out_data` is stable while stalled; `done` is delayed by exactly the number of stalled HOLD cycles; `sum`=1488.
- Wrap/overflow of `sum`:
  - Stimulus: set every register to 0xFFFF_FFFF (x0=0).
  - Required: `sum`=0xFFFF_FFE1 (31·0xFFFFFFFF mod 2^32).
- Start while busy:
  - Stimulus: pulse `start` at cycles 10 and 40 of a dump.
  - Required: the dump is unaffected; exactly one `done` pulse; returns to IDLE.
- Reset mid-dump:
  - Stimulus: drop `rst_n` during HOLD at idx=12, then release and issue `start`.
  - Required: all outputs are 0 immediately on reset; no `done` pulse; the new dump starts from idx 0 and produces the full 1488 `sum`.
- Back-to-back:
  - Stimulus: hold `start`=1 continuously.
  - Required: successive dumps separated by one IDLE cycle; `own` is 0 in the FIN and IDLE cycles.

Source files
------------

// File: rtl/regfile_dumper.sv
// regfile_dumper: streams every register-file entry as an (index, value) beat
// over a valid/ready handshake and keeps a running modulo-2^DW sum of them.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request a dump (honoured only when idle)
//   own               1 while rs1 must come from this block instead of the decoder
//   rs1 / rv1         regfile read address / combinational read data
//   out_valid/ready   handshake for the out_idx / out_data beat
//   busy, done        activity flag, one-cycle completion pulse
//   sum               modulo-2^DW sum of all accepted out_data values
module regfile_dumper #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          own,
  output logic [AW-1:0] rs1,
  input  logic [DW-1:0] rv1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          own_q, own_d;
  logic [AW-1:0] rs1_q, rs1_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and datapath; status outputs are decoded from the next state
  // so they are registered yet line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        out_data_d = rv1;
        out_idx_d  = idx_q;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          sum_d = DW'(sum_q + out_data_q);
          if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            idx_d   = AW'(idx_q + AW'(1));
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    own_d       = (state_d == S_READ) || (state_d == S_HOLD);
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    rs1_d       = idx_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      own_q       <= 1'b0;
      rs1_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      own_q       <= own_d;
      rs1_q       <= rs1_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign own       = own_q;
  assign rs1       = rs1_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: a behavioural regfile with an rs1 mux,
// dumps under full-rate, backpressure, start-while-busy, reset and
// back-to-back stimulus, with expectations computed from the bench's regfile.
module tb_regfile_dumper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        own;
  logic [4:0]  rs1;
  logic [31:0] rv1;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] sum;

  logic [31:0] regs [32];
  logic [4:0]  dec_addr;
  logic [4:0]  rf_addr;

  int errors;
  int checks;

  regfile_dumper #(.NREGS(32), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .own       (own),
    .rs1       (rs1),
    .rv1       (rv1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rs1 mux and hardwired-x0 regfile read
  assign rf_addr = own ? rs1 : dec_addr;
  assign rv1     = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_val(input int k);
    return (k == 0) ? 32'd0 : regs[k];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".own"},       32'(own),       32'd0);
    chk({tag, ".rs1"},       32'(rs1),       32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_idx"},   32'(out_idx),   32'd0);
    chk({tag, ".out_data"},  out_data,       32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
    chk({tag, ".sum"},       sum,            32'd0);
  endtask

  // mode 0: ready held 1; mode 1: ready 1,0,0 per HOLD cycle; mode 2: extra
  // start pulses at cycles 10 and 40.
  task automatic run_dump(input int mode, input logic [31:0] exp_sum, input string nm);
    int          cyc;
    int          beats;
    int          stalls;
    int          dones;
    int          done_cyc;
    int          h;
    logic        rdy;
    logic        stalled;
    logic [31:0] held_d;
    logic [4:0]  held_i;
    beats = 0; stalls = 0; dones = 0; done_cyc = -1; h = 0; stalled = 1'b0;
    held_d = '0; held_i = '0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk({nm, ".own_c1"}, 32'(own), 32'd1);
    while (dones == 0 && cyc < 400) begin
      if (mode == 2) start = (cyc == 10 || cyc == 40);
      rdy = (mode == 1) ? (h % 3 == 0) : 1'b1;
      if (out_valid) begin
        if (stalled) begin
          chk({nm, ".stall_idx"},  32'(out_idx), 32'(held_i));
          chk({nm, ".stall_data"}, out_data,     held_d);
        end
        if (rdy) begin
          chk({nm, ".idx"},  32'(out_idx), 32'(beats));
          chk({nm, ".data"}, out_data,     exp_val(beats));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_i  = out_idx;
          held_d  = out_data;
          stalls++;
        end
        h++;
      end else if (own) begin
        chk({nm, ".rs1"}, 32'(rs1), 32'(beats));
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk({nm, ".sum"},     sum,       exp_sum);
        chk({nm, ".own_fin"}, 32'(own),  32'd0);
        chk({nm, ".busy_fin"}, 32'(busy), 32'd1);
      end
      out_ready = rdy;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({nm, ".done_seen"}, 32'(dones),    32'd1);
    chk({nm, ".beats"},     32'(beats),    32'd32);
    chk({nm, ".done_cyc"},  32'(done_cyc), 32'(65 + stalls));
    chk({nm, ".idle_busy"}, 32'(busy),     32'd0);
    chk({nm, ".idle_done"}, 32'(done),     32'd0);
    chk({nm, ".sum_hold"},  sum,           exp_sum);
    tick();
    chk({nm, ".stay_idle"}, 32'(busy),     32'd0);
    if (mode == 1) chk({nm, ".stalls_seen"}, 32'(stalls > 0), 32'd1);
  endtask

  initial begin
    int cyc;
    int dcount;
    int d1;
    int d2;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    dec_addr = 5'd7;
    for (int k = 0; k < 32; k++) regs[k] = 32'(3 * k);
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_dump(0, 32'd1488, "directed");
    run_dump(1, 32'd1488, "backpressure");
    run_dump(2, 32'd1488, "start_busy");

    for (int k = 0; k < 32; k++) regs[k] = 32'hFFFF_FFFF;
    run_dump(0, 32'hFFFF_FFE1, "wrap");
    for (int k = 0; k < 32; k++) regs[k] = 32'(3 * k);

    // Reset in HOLD at idx 12
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_idx == 5'd12) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rst.reach_idx12", 32'(out_idx), 32'd12);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    chk("rst.no_done_a", 32'(done), 32'd0);
    tick();
    chk("rst.no_done_b", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.idle", 32'(busy), 32'd0);
    run_dump(0, 32'd1488, "after_rst");

    // Back-to-back with start held
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    cyc = 1;
    dcount = 0; d1 = -1; d2 = -1;
    while (cyc <= 140) begin
      if (done) begin
        dcount++;
        if (dcount == 1) d1 = cyc;
        if (dcount == 2) d2 = cyc;
        chk("b2b.own_fin", 32'(own), 32'd0);
      end
      if (cyc == 66) begin
        chk("b2b.idle_busy", 32'(busy), 32'd0);
        chk("b2b.idle_own",  32'(own),  32'd0);
      end
      if (cyc == 67) begin
        chk("b2b.read_own", 32'(own), 32'd1);
        chk("b2b.read_rs1", 32'(rs1), 32'd0);
        chk("b2b.sum_clr_pending", sum, 32'd0);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("b2b.done_count", 32'(dcount), 32'd2);
    chk("b2b.done1", 32'(d1), 32'd65);
    chk("b2b.done2", 32'(d2), 32'd131);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
